// File: rtl/seq_divider_pkg.sv
// Shared constants, FSM state type and the 1-bit adder cell for the sequential divider.
package seq_divider_pkg;

  localparam int unsigned DivWidth    = 16;
  localparam int unsigned DivCntWidth = $clog2(DivWidth + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } div_state_e;

  // Datapath full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: ripple subtract of the divisor from T and restore-or-keep select.
module seq_divider_div_step
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic [WIDTH:0]   t_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] r_next_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] sub_b;
  logic [WIDTH:0] diff;
  logic [WIDTH+1:0] carry;

  assign sub_b = ~{1'b0, divisor_i};

  // Two's complement subtract: T + ~{0,divisor} + 1; carry-out of 1 means no borrow.
  always_comb begin
    diff     = '0;
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 0; i <= int'(WIDTH); i++) begin
      {carry[i+1], diff[i]} = full_add(t_i[i], sub_b[i], carry[i]);
    end
  end

  assign q_bit_o  = carry[WIDTH+1];
  assign r_next_o = q_bit_o ? diff[WIDTH-1:0] : t_i[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional DIVIDER_ZERO_DETECT_EN: zero divisor short-circuits to DONE and raises div_zero.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  div_state_e       state_q;
  logic [WIDTH-1:0] r_q, q_q, divisor_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] r_next;
  logic             q_bit;
`ifdef DIVIDER_ZERO_DETECT_EN
  logic             zero_q, dz_q;
`endif

  seq_divider_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .t_i      ({r_q, q_q[WIDTH-1]}),
    .divisor_i(divisor_q),
    .r_next_o (r_next),
    .q_bit_o  (q_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      r_q         <= '0;
      q_q         <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DIVIDER_ZERO_DETECT_EN
      zero_q      <= 1'b0;
      dz_q        <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          if (start) begin
            r_q       <= '0;
            q_q       <= dividend;
            divisor_q <= divisor;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= StRun;
`ifdef DIVIDER_ZERO_DETECT_EN
            zero_q    <= (divisor == '0);
            dz_q      <= 1'b0;
`endif
          end
        end
        StRun: begin
`ifdef DIVIDER_ZERO_DETECT_EN
          // q_q still holds the untouched dividend on this first RUN cycle.
          if (zero_q) begin
            state_q     <= StDone;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= '1;
            remainder_q <= q_q;
            dz_q        <= 1'b1;
          end else
`endif
          begin
            r_q   <= r_next;
            q_q   <= {q_q[WIDTH-2:0], q_bit};
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntW'(WIDTH - 1)) begin
              state_q     <= StDone;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              quotient_q  <= {q_q[WIDTH-2:0], q_bit};
              remainder_q <= r_next;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
`ifdef DIVIDER_ZERO_DETECT_EN
  assign div_zero  = dz_q;
`else
  assign div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider: results, latency, handshake and mid-op reset.
module tb_seq_divider;

`ifdef DIVIDER_ZERO_DETECT_EN
  localparam int ZdLat  = 1;
  localparam int ZdFlag = 1;
`else
  localparam int ZdLat  = 16;
  localparam int ZdFlag = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend, divisor;
  logic        busy, done, div_zero;
  logic [15:0] quotient, remainder;

  int checks = 0;
  int errors = 0;
  int both_high = 0;

  always #5 clk = ~clk;

  seq_divider dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    int          lat;
    int          dz;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Wait for done after an accepting edge; lat = cycles after that edge, -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (busy && done) both_high++;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    wait_done(lat);
  endtask

  vec_t vecs[6];
  int   lat;
  int   done_seen;
  logic [15:0] ra, rb;

  initial begin
    vecs[0] = '{16'd100,   16'd7,      16'd14,     16'd2,    16, 0};
    vecs[1] = '{16'hFFFF,  16'd1,      16'hFFFF,   16'd0,    16, 0};
    vecs[2] = '{16'd5,     16'd9,      16'd0,      16'd5,    16, 0};
    vecs[3] = '{16'd0,     16'd3,      16'd0,      16'd0,    16, 0};
    vecs[4] = '{16'hFFFF,  16'hFFFF,   16'd1,      16'd0,    16, 0};
    vecs[5] = '{16'd1234,  16'd0,      16'hFFFF,   16'd1234, ZdLat, ZdFlag};

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_q", 32'(quotient), 0);
    check("reset_r", 32'(remainder), 0);
    check("reset_dz", 32'(div_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_q", i), 32'(quotient), 32'(vecs[i].q));
      check($sformatf("vec%0d_r", i), 32'(remainder), 32'(vecs[i].r));
      check($sformatf("vec%0d_dz", i), 32'(div_zero), vecs[i].dz);
    end

    // Start held through RUN with operands changed mid-run, then re-accepted in DONE.
    @(negedge clk);
    dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    done_seen = 0;
    for (int n = 1; n <= 15; n++) begin
      @(posedge clk); #1;
      if (n == 5) begin dividend = 16'd50000; divisor = 16'd3; end
      if (!busy || done) done_seen++;
    end
    check("hs_busy_held", done_seen, 0);
    @(posedge clk); #1;
    check("hs_done1", 32'(done), 1);
    check("hs_q1", 32'(quotient), 14);
    check("hs_r1", 32'(remainder), 2);
    @(posedge clk); #1;
    start = 1'b0;
    check("hs_busy2", 32'(busy), 1);
    wait_done(lat);
    check("hs_latency2", lat, 16);
    check("hs_q2", 32'(quotient), 16666);
    check("hs_r2", 32'(remainder), 2);

    // Reset after step 8 abandons the operation silently.
    @(negedge clk);
    dividend = 16'd1000; divisor = 16'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_q", 32'(quotient), 0);
    check("rst_r", 32'(remainder), 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    check("rst_no_done", done_seen, 0);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = (i % 4 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
      run_op(ra, rb, lat);
      check("rand_latency", lat, 16);
      check("rand_identity", 32'(quotient) * 32'(rb) + 32'(remainder), 32'(ra));
      check("rand_r_lt_d", 32'(remainder < rb), 1);
    end

    check("busy_done_exclusive", both_high, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
